// File: rtl/io_ring_power_sequencer.sv
// io_ring_power_sequencer
// Sequences the IO-ring clamp (ngate) and the per-group pad driver enables.
// The clamp is released after both supplies have been good for a debounced
// interval. Pad groups are then enabled one at a time, and are torn down in
// reverse order on request. On supply loss everything drops at once.
module io_ring_power_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NGROUPS         = 4,
    parameter int STAGE_CYCLES    = 8
) (
    input  logic               ck,
    input  logic               nrst,
    input  logic               iovdd_ok,
    input  logic               vdd_ok,
    input  logic               req_off,
    output logic               ngate,
    output logic [NGROUPS-1:0] pad_de_en,
    output logic               ready,
    output logic               fault
);

    localparam logic [7:0]         DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]         STG_LAST = 8'(STAGE_CYCLES - 1);
    localparam logic [NGROUPS-1:0] GRP0     = NGROUPS'(1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DEBOUNCE,
        ST_RELEASE,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         deb_cnt_q, deb_cnt_d;
    logic [7:0]         stg_cnt_q, stg_cnt_d;
    logic               ngate_q, ngate_d;
    logic [NGROUPS-1:0] pad_de_en_q, pad_de_en_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    logic               supply_ok;
    logic               stg_last;
    logic [7:0]         stg_inc;
    logic [7:0]         deb_inc;
    logic [NGROUPS-1:0] pad_up;
    logic [NGROUPS-1:0] pad_dn;

    assign supply_ok = iovdd_ok & vdd_ok;
    assign stg_last  = (stg_cnt_q == STG_LAST);
    assign stg_inc   = (stg_cnt_q == 8'hFF) ? stg_cnt_q : stg_cnt_q + 8'd1;
    assign deb_inc   = (deb_cnt_q == 8'hFF) ? deb_cnt_q : deb_cnt_q + 8'd1;
    // Enables form a contiguous low-order run, so the next group to enable is
    // a shift-in of a one and the group to disable is a shift-out at the top;
    // the run length itself serves as the group index.
    assign pad_up    = (pad_de_en_q << 1) | GRP0;
    assign pad_dn    = pad_de_en_q >> 1;

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        stg_cnt_d   = stg_cnt_q;
        ngate_d     = ngate_q;
        pad_de_en_d = pad_de_en_q;
        ready_d     = ready_q;
        fault_d     = fault_q;

        if (!supply_ok && (state_q inside {ST_RELEASE, ST_RAMP_UP, ST_ON, ST_RAMP_DOWN})) begin
            // Supply loss beats any shutdown request: drop everything now.
            pad_de_en_d = '0;
            ngate_d     = 1'b1;
            ready_d     = 1'b0;
            fault_d     = fault_q | (|pad_de_en_q);
            state_d     = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    ngate_d     = 1'b1;
                    pad_de_en_d = '0;
                    ready_d     = 1'b0;
                    if (supply_ok && !req_off) begin
                        deb_cnt_d = '0;
                        state_d   = ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!supply_ok || req_off) begin
                        state_d = ST_OFF;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        ngate_d   = 1'b0;
                        stg_cnt_d = '0;
                        state_d   = ST_RELEASE;
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end

                // The release cycle is the first cycle of the first stage, so
                // group 0 comes up exactly STAGE_CYCLES after ngate falls.
                ST_RELEASE, ST_RAMP_UP: begin
                    if (state_q == ST_RAMP_UP && req_off) begin
                        stg_cnt_d = '0;
                        ready_d   = 1'b0;
                        state_d   = ST_RAMP_DOWN;
                    end else begin
                        state_d = ST_RAMP_UP;
                        if (stg_last) begin
                            pad_de_en_d = pad_up;
                            stg_cnt_d   = '0;
                            if (pad_up[NGROUPS-1]) begin
                                state_d = ST_ON;
                            end
                        end else begin
                            stg_cnt_d = stg_inc;
                        end
                    end
                end

                ST_ON: begin
                    ready_d = 1'b1;
                    if (req_off) begin
                        ready_d   = 1'b0;
                        stg_cnt_d = '0;
                        state_d   = ST_RAMP_DOWN;
                    end
                end

                // Shutdown is committed once started; req_off is ignored here.
                ST_RAMP_DOWN: begin
                    ready_d = 1'b0;
                    if (stg_last) begin
                        stg_cnt_d = '0;
                        if (|pad_de_en_q) begin
                            pad_de_en_d = pad_dn;
                        end else begin
                            ngate_d = 1'b1;
                            state_d = ST_OFF;
                        end
                    end else begin
                        stg_cnt_d = stg_inc;
                    end
                end

                default: begin
                    ngate_d     = 1'b1;
                    pad_de_en_d = '0;
                    ready_d     = 1'b0;
                    state_d     = ST_OFF;
                end
            endcase
        end
    end

    // State and output registers; reset leaves the ring clamped and idle.
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_OFF;
            deb_cnt_q   <= '0;
            stg_cnt_q   <= '0;
            ngate_q     <= 1'b1;
            pad_de_en_q <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            stg_cnt_q   <= stg_cnt_d;
            ngate_q     <= ngate_d;
            pad_de_en_q <= pad_de_en_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign ngate     = ngate_q;
    assign pad_de_en = pad_de_en_q;
    assign ready     = ready_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_io_ring_power_sequencer.sv
// tb_io_ring_power_sequencer
// Two sequencers share one stimulus stream: the default configuration and
// the minimal one (1/1/1). Each cycle's expected outputs come from a timeline
// model (elapsed cycles since the relevant event, divided by the stage length)
// and are queued; a monitor pops and compares after every clock edge.
module tb_io_ring_power_sequencer;

    localparam int D_A = 16;
    localparam int N_A = 4;
    localparam int S_A = 8;
    localparam int D_B = 1;
    localparam int N_B = 1;
    localparam int S_B = 1;

    logic           ck = 1'b0;
    logic           nrst = 1'b0;
    logic           iovdd_ok = 1'b0;
    logic           vdd_ok = 1'b0;
    logic           req_off = 1'b0;

    logic           ngate_a;
    logic [N_A-1:0] pad_a;
    logic           ready_a;
    logic           fault_a;
    logic           ngate_b;
    logic [N_B-1:0] pad_b;
    logic           ready_b;
    logic           fault_b;

    always #5 ck = ~ck;

    io_ring_power_sequencer #(
        .DEBOUNCE_CYCLES(D_A), .NGROUPS(N_A), .STAGE_CYCLES(S_A)
    ) dut_a (
        .ck(ck), .nrst(nrst), .iovdd_ok(iovdd_ok), .vdd_ok(vdd_ok),
        .req_off(req_off), .ngate(ngate_a), .pad_de_en(pad_a),
        .ready(ready_a), .fault(fault_a)
    );

    io_ring_power_sequencer #(
        .DEBOUNCE_CYCLES(D_B), .NGROUPS(N_B), .STAGE_CYCLES(S_B)
    ) dut_b (
        .ck(ck), .nrst(nrst), .iovdd_ok(iovdd_ok), .vdd_ok(vdd_ok),
        .req_off(req_off), .ngate(ngate_b), .pad_de_en(pad_b),
        .ready(ready_b), .fault(fault_b)
    );

    typedef enum int {M_IDLE, M_UP, M_DOWN} mode_t;

    typedef struct {
        mode_t mode;
        int    t_up;    // first supply-good cycle of the current debounce, -1 if none
        int    t_fall;  // cycle whose edge released the clamp
        int    t_dn;    // cycle whose edge started the shutdown
        int    k0;      // groups enabled when shutdown started
        int    k;       // groups currently enabled
        bit    ngate;
        bit    ready;
        bit    fault;
    } model_t;

    typedef struct packed {
        int         n;
        logic       ngate;
        logic [7:0] pad;
        logic       ready;
        logic       fault;
    } exp_t;

    model_t ma;
    model_t mb;
    exp_t   qa[$];
    exp_t   qb[$];
    int     n_cyc = 0;
    int     tests = 0;
    int     fails = 0;

    function automatic model_t model_reset();
        model_t r;
        r.mode   = M_IDLE;
        r.t_up   = -1;
        r.t_fall = 0;
        r.t_dn   = 0;
        r.k0     = 0;
        r.k      = 0;
        r.ngate  = 1'b1;
        r.ready  = 1'b0;
        r.fault  = 1'b0;
        return r;
    endfunction

    // Outputs after the edge that ends cycle n, given that cycle's inputs.
    function automatic model_t model_step(model_t m, int d, int ng, int s,
                                          bit ok, bit rq, int n);
        model_t r;
        int     e;
        r = m;
        if (m.mode != M_IDLE && !ok) begin
            r.fault = m.fault | (m.k != 0);
            r.k     = 0;
            r.ngate = 1'b1;
            r.ready = 1'b0;
            r.mode  = M_IDLE;
            r.t_up  = -1;
        end else if (m.mode == M_IDLE) begin
            if (!ok || rq) begin
                r.t_up = -1;
            end else begin
                if (r.t_up < 0) r.t_up = n;
                if (n - r.t_up == d) begin
                    r.mode   = M_UP;
                    r.t_fall = n;
                    r.ngate  = 1'b0;
                end
            end
        end else if (m.mode == M_UP) begin
            e = n - m.t_fall;
            // e == 1 is the release cycle, where a request is not yet seen.
            if (rq && e >= 2) begin
                r.mode  = M_DOWN;
                r.t_dn  = n;
                r.k0    = m.k;
                r.ready = 1'b0;
            end else begin
                r.k     = (e / s > ng) ? ng : e / s;
                r.ready = (e >= ng * s + 1);
            end
        end else begin
            e = n - m.t_dn;
            r.k = (m.k0 - e / s < 0) ? 0 : m.k0 - e / s;
            if (e >= (m.k0 + 1) * s) begin
                r.ngate = 1'b1;
                r.mode  = M_IDLE;
                r.t_up  = -1;
            end
        end
        return r;
    endfunction

    function automatic exp_t to_exp(model_t m, int n);
        exp_t x;
        int   v;
        v       = (1 << m.k) - 1;
        x.n     = n;
        x.ngate = m.ngate;
        x.pad   = 8'(v);
        x.ready = m.ready;
        x.fault = m.fault;
        return x;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One stimulus cycle: drive inputs, advance both models, queue expectations.
    task automatic cycle(input bit io, input bit vd, input bit rq);
        @(negedge ck);
        iovdd_ok = io;
        vdd_ok   = vd;
        req_off  = rq;
        n_cyc++;
        ma = model_step(ma, D_A, N_A, S_A, io & vd, rq, n_cyc);
        mb = model_step(mb, D_B, N_B, S_B, io & vd, rq, n_cyc);
        qa.push_back(to_exp(ma, n_cyc));
        qb.push_back(to_exp(mb, n_cyc));
    endtask

    task automatic sample();
        @(posedge ck);
        #1;
    endtask

    task automatic cmp(input string name, input exp_t act, input exp_t want);
        tests++;
        if (act.ngate !== want.ngate || act.pad !== want.pad ||
            act.ready !== want.ready || act.fault !== want.fault) begin
            fails++;
            $display("FAIL %s cycle %0d: got ngate=%0b pad=%h ready=%0b fault=%0b, expected ngate=%0b pad=%h ready=%0b fault=%0b",
                     name, want.n, act.ngate, act.pad, act.ready, act.fault,
                     want.ngate, want.pad, want.ready, want.fault);
        end
    endtask

    // Scoreboard monitor: compare every queued expectation after its edge.
    always begin
        exp_t act;
        exp_t want;
        @(posedge ck);
        #1;
        if (qa.size() > 0) begin
            want      = qa.pop_front();
            act       = want;
            act.ngate = ngate_a;
            act.pad   = {4'b0, pad_a};
            act.ready = ready_a;
            act.fault = fault_a;
            cmp("sb_a", act, want);
        end
        if (qb.size() > 0) begin
            want      = qb.pop_front();
            act       = want;
            act.ngate = ngate_b;
            act.pad   = {7'b0, pad_b};
            act.ready = ready_b;
            act.fault = fault_b;
            cmp("sb_b", act, want);
        end
    end

    initial begin
        ma = model_reset();
        mb = model_reset();

        // Reset state.
        repeat (3) @(posedge ck);
        #1;
        check("rst ngate_a", 8'(ngate_a), 8'h1);
        check("rst pad_a",   8'(pad_a),   8'h0);
        check("rst ready_a", 8'(ready_a), 8'h0);
        check("rst fault_a", 8'(fault_a), 8'h0);
        check("rst ngate_b", 8'(ngate_b), 8'h1);
        @(negedge ck);
        nrst = 1'b1;

        // Power-up with both supplies held good.
        for (int c = 0; c < 60; c++) begin
            cycle(1'b1, 1'b1, 1'b0);
            sample();
            if (c == 15) check("pu ngate_a c15", 8'(ngate_a), 8'h1);
            if (c == 16) check("pu ngate_a c16", 8'(ngate_a), 8'h0);
            if (c == 23) check("pu pad_a c23",   8'(pad_a),   8'h0);
            if (c == 24) check("pu pad_a c24",   8'(pad_a),   8'h1);
            if (c == 32) check("pu pad_a c32",   8'(pad_a),   8'h3);
            if (c == 40) check("pu pad_a c40",   8'(pad_a),   8'h7);
            if (c == 48) check("pu pad_a c48",   8'(pad_a),   8'hf);
            if (c == 48) check("pu ready_a c48", 8'(ready_a), 8'h0);
            if (c == 49) check("pu ready_a c49", 8'(ready_a), 8'h1);
            if (c == 0)  check("pu ngate_b c0",  8'(ngate_b), 8'h1);
            if (c == 1)  check("pu ngate_b c1",  8'(ngate_b), 8'h0);
            if (c == 1)  check("pu pad_b c1",    8'(pad_b),   8'h0);
            if (c == 2)  check("pu pad_b c2",    8'(pad_b),   8'h1);
            if (c == 2)  check("pu ready_b c2",  8'(ready_b), 8'h0);
            if (c == 3)  check("pu ready_b c3",  8'(ready_b), 8'h1);
        end

        // Orderly shutdown from ON with a one-cycle request pulse.
        for (int c = 0; c < 45; c++) begin
            cycle(1'b1, 1'b1, c == 0);
            sample();
            if (c == 0)  check("off ready_a +0", 8'(ready_a), 8'h0);
            if (c == 8)  check("off pad_a +8",   8'(pad_a),   8'h7);
            if (c == 16) check("off pad_a +16",  8'(pad_a),   8'h3);
            if (c == 24) check("off pad_a +24",  8'(pad_a),   8'h1);
            if (c == 32) check("off pad_a +32",  8'(pad_a),   8'h0);
            if (c == 39) check("off ngate_a +39", 8'(ngate_a), 8'h0);
            if (c == 40) check("off ngate_a +40", 8'(ngate_a), 8'h1);
            if (c == 40) check("off fault_a +40", 8'(fault_a), 8'h0);
        end

        // Let it power back up, then drop the IO supply while ON.
        for (int c = 0; c < 60; c++) cycle(1'b1, 1'b1, 1'b0);
        sample();
        check("on ready_a", 8'(ready_a), 8'h1);
        cycle(1'b0, 1'b1, 1'b0);
        sample();
        check("loss ngate_a", 8'(ngate_a), 8'h1);
        check("loss pad_a",   8'(pad_a),   8'h0);
        check("loss ready_a", 8'(ready_a), 8'h0);
        check("loss fault_a", 8'(fault_a), 8'h1);
        for (int c = 0; c < 60; c++) cycle(1'b1, 1'b1, 1'b0);
        sample();
        check("repower ready_a", 8'(ready_a), 8'h1);
        check("repower fault_a", 8'(fault_a), 8'h1);

        // Asynchronous reset between edges, mid ramp-up.
        cycle(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 30; c++) cycle(1'b1, 1'b1, 1'b0);
        sample();
        check("pre-rst pad_a", 8'(pad_a), 8'h1);
        #2;
        nrst     = 1'b0;
        iovdd_ok = 1'b0;
        vdd_ok   = 1'b0;
        req_off  = 1'b0;
        ma       = model_reset();
        mb       = model_reset();
        #1;
        check("arst ngate_a", 8'(ngate_a), 8'h1);
        check("arst pad_a",   8'(pad_a),   8'h0);
        check("arst ready_a", 8'(ready_a), 8'h0);
        check("arst fault_a", 8'(fault_a), 8'h0);
        check("arst fault_b", 8'(fault_b), 8'h0);
        repeat (2) @(posedge ck);
        @(negedge ck);
        nrst = 1'b1;

        // Debounce glitch at cycle 10, then ramp to pad=0011 and hit it with
        // a shutdown request and a supply loss on the same cycle.
        for (int c = 0; c < 45; c++) begin
            cycle(1'b1, c != 10, 1'b0);
            sample();
            if (c == 10) check("glitch ngate_a c10", 8'(ngate_a), 8'h1);
            if (c == 16) check("glitch ngate_a c16", 8'(ngate_a), 8'h1);
            if (c == 26) check("glitch ngate_a c26", 8'(ngate_a), 8'h1);
            if (c == 27) check("glitch ngate_a c27", 8'(ngate_a), 8'h0);
            if (c == 43) check("glitch pad_a c43",   8'(pad_a),   8'h3);
        end
        cycle(1'b1, 1'b0, 1'b1);
        sample();
        check("simul ngate_a", 8'(ngate_a), 8'h1);
        check("simul pad_a",   8'(pad_a),   8'h0);
        check("simul ready_a", 8'(ready_a), 8'h0);
        check("simul fault_a", 8'(fault_a), 8'h1);

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 249) != 0,
                  $urandom_range(0, 249) != 0,
                  $urandom_range(0, 79) == 0);
        end

        sample();
        #1;
        check("queue a drained", 8'(qa.size()), 8'h0);
        check("queue b drained", 8'(qb.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_ring_power_sequencer.md
Name: io_ring_power_sequencer

Overview:
- Digital sequencer sitting directly upstream of the IO-ring supply pads (IOVdd/IOVss) and the signal pads they power.
- Drives the pad-ring ngate/clamp control and per-group pad driver enables (de gating).
- Releases the clamp only after IO and core supplies report good for a debounced interval, then enables pad groups one at a time.
- Tears groups down in reverse order on request, and immediately on supply loss.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles both supply-good inputs must be high before the clamp is released; legal range 1..255.
- NGROUPS, 4: number of pad driver groups; legal range 1..8.
- STAGE_CYCLES, 8: cycles between successive group enable or disable steps; legal range 1..255.

Ports:
- ck  input  1  clock
- nrst  input  1  asynchronous active-low reset
- iovdd_ok  input  1  IO supply good, already synchronised to ck
- vdd_ok  input  1  core supply good, already synchronised to ck
- req_off  input  1  level request for orderly shutdown
- ngate  output  1  ring clamp gate; 1 = clamp active, 0 = clamp released
- pad_de_en  output  NGROUPS  per-group driver enable; bit i gates group i
- ready  output  1  all groups enabled
- fault  output  1  sticky; set on supply loss while any group is enabled

Behaviour:
- Reset (nrst low, asynchronous):
  - state = OFF, ngate = 1, pad_de_en = 0, ready = 0, fault = 0, counters = 0.
  - Reset mid-sequence aborts immediately with the same values.
- All outputs are registered; no combinational path from input to output.
- supply_ok = iovdd_ok & vdd_ok.
- States:
  - OFF:
    - Outputs: ngate = 1, pad_de_en = 0, ready = 0.
    - Go to DEBOUNCE when supply_ok = 1 and req_off = 0; the debounce counter is cleared on entry.
  - DEBOUNCE:
    - Counter increments each cycle while supply_ok = 1.
    - supply_ok = 0 returns to OFF.
    - Counter reaching DEBOUNCE_CYCLES-1 with supply_ok = 1 goes to RELEASE.
    - Net effect: first supply_ok high cycle in OFF = cycle 0; ngate falls at the clock edge ending cycle DEBOUNCE_CYCLES.
  - RELEASE:
    - ngate = 0. Stage counter cleared; group index g = 0.
    - Next cycle goes to RAMP_UP.
  - RAMP_UP:
    - Stage counter counts to STAGE_CYCLES-1, then sets pad_de_en[g] and increments g.
    - Group 0 is enabled STAGE_CYCLES cycles after ngate falls; groups follow at STAGE_CYCLES spacing.
    - After bit NGROUPS-1 is set, go to ON.
  - ON:
    - ready = 1, asserted the cycle after the last enable bit is set.
  - RAMP_DOWN:
    - Entered from ON or RAMP_UP when req_off = 1; ready drops on entry.
    - Clears the highest set bit of pad_de_en every STAGE_CYCLES cycles, first clear STAGE_CYCLES cycles after entry.
    - When pad_de_en = 0, waits STAGE_CYCLES more cycles, then sets ngate = 1 and goes to OFF.
    - req_off deasserting during RAMP_DOWN does not abort; the shutdown completes.
- Supply loss (supply_ok = 0 in RELEASE, RAMP_UP, ON or RAMP_DOWN) has priority over req_off. On the next edge:
  - pad_de_en = 0, ngate = 1, ready = 0.
  - fault = 1 if pad_de_en was non-zero.
  - Go to OFF.
- fault is cleared only by nrst.
- req_off = 1 in OFF or DEBOUNCE holds or returns the block to OFF.
- Counters saturate; no wrap-around behaviour is reachable with legal parameters.
- pad_de_en bits are always a contiguous low-order run: 0, 1, 3, 7, … .

Test Plan:
- Power-up: reset, then iovdd_ok = vdd_ok = 1 held; defaults.
  - ngate falls at cycle 16.
  - pad_de_en = 0001/0011/0111/1111 at cycles 24/32/40/48.
  - ready = 1 at cycle 49.
- Debounce glitch: vdd_ok low for 1 cycle at cycle 10 of debounce.
  - Returns to OFF; ngate stays 1.
  - Full 16-cycle debounce restarts on recovery.
- Orderly off: from ON, pulse req_off for one cycle.
  - ready = 0 next cycle.
  - pad_de_en = 0111/0011/0001/0000 at +8/+16/+24/+32.
  - ngate = 1 at +40; fault stays 0.
- Supply loss in ON: drop iovdd_ok.
  - Next edge: pad_de_en = 0, ngate = 1, ready = 0, fault = 1.
  - fault persists after the supply returns and a new power-up completes.
- Simultaneous events: req_off = 1 and vdd_ok = 0 on the same cycle in RAMP_UP with pad_de_en = 0011.
  - Supply-loss path taken; fault = 1.
- Async reset mid-RAMP_UP: nrst low between clock edges.
  - Outputs go to reset values immediately without a clock.
  - Parameter sweep NGROUPS = 1, STAGE_CYCLES = 1 and DEBOUNCE_CYCLES = 1: ngate falls at cycle 1, group 0 enables at cycle 2, ready = 1 at cycle 3.
